// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin front end sharing one SPI master.
// Optional START/XFER watchdog is compiled in when SPI_ARB_WDOG_EN is defined.
module spi_arbiter #(
    parameter int START_TO = 16,
    parameter int XFER_TO  = 4096
) (
    input  logic        GCLK,
    input  logic        RST,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [1:0]  req0_mode_i,
    input  logic [1:0]  req0_speed_i,
    input  logic [1:0]  req0_len_i,
    input  logic [31:0] req0_mosi_i,
    output logic        req0_done_o,
    output logic [31:0] req0_miso_o,
    output logic        req0_err_o,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [1:0]  req1_mode_i,
    input  logic [1:0]  req1_speed_i,
    input  logic [1:0]  req1_len_i,
    input  logic [31:0] req1_mosi_i,
    output logic        req1_done_o,
    output logic [31:0] req1_miso_o,
    output logic        req1_err_o,
    input  logic [7:0]  ifg_i,
    input  logic [7:0]  cs_sck_i,
    input  logic [7:0]  sck_cs_i,
    output logic [7:0]  ifg_o,
    output logic [7:0]  cs_sck_o,
    output logic [7:0]  sck_cs_o,
    output logic        spi_start_o,
    input  logic        spi_busy_i,
    output logic [1:0]  spi_mode_o,
    output logic [1:0]  spi_speed_o,
    output logic [1:0]  spi_len_o,
    output logic [31:0] spi_mosi_o,
    input  logic [31:0] spi_miso_i
);

    // state | meaning
    // IDLE  | waiting for a request; grants one and latches its fields
    // LOAD  | latched config on spi_* outputs, start not yet raised
    // START | spi_start_o high until the master reports busy
    // XFER  | master busy; miso captured when busy falls
    // DONE  | owner's done (and err) pulse visible for one cycle
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_XFER, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_owner, r_last;
    logic        r_ready0, r_ready1, r_done0, r_done1, r_start;
    logic [1:0]  r_mode, r_speed, r_len;
    logic [31:0] r_mosi, r_miso0, r_miso1;
    logic        w_grant, w_grant_id, w_capture, w_finish;
    logic        w_start_to, w_xfer_to;

    assign w_grant    = (r_state == S_IDLE) && (req0_valid_i || req1_valid_i);
    // On a tie, the requester that did not win last time is served.
    assign w_grant_id = (req0_valid_i && req1_valid_i) ? ~r_last : req1_valid_i;
    assign w_capture  = (r_state == S_XFER) && !spi_busy_i;
    assign w_finish   = w_capture || w_start_to || w_xfer_to;

`ifdef SPI_ARB_WDOG_EN
    localparam logic [15:0] START_LIM = 16'(START_TO - 1);
    localparam logic [15:0] XFER_LIM  = 16'(XFER_TO - 1);

    logic [15:0] r_wdog;
    logic        r_err0, r_err1;

    assign w_start_to = (r_state == S_START) && !spi_busy_i && (r_wdog == START_LIM);
    assign w_xfer_to  = (r_state == S_XFER)  &&  spi_busy_i && (r_wdog == XFER_LIM);

    always_ff @(posedge GCLK) begin
        if (RST) begin
            r_wdog <= '0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            // Any state change restarts the count, so START and XFER each get a fresh budget.
            if (w_next != r_state)
                r_wdog <= '0;
            else if (r_state == S_START || r_state == S_XFER)
                r_wdog <= r_wdog + 16'd1;
            r_err0 <= (w_start_to || w_xfer_to) && !r_owner;
            r_err1 <= (w_start_to || w_xfer_to) &&  r_owner;
        end
    end

    assign req0_err_o = r_err0;
    assign req1_err_o = r_err1;
`else
    assign w_start_to = 1'b0;
    assign w_xfer_to  = 1'b0;
    assign req0_err_o = 1'b0;
    assign req1_err_o = 1'b0;
`endif

    always_ff @(posedge GCLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_LOAD;
            S_LOAD:  w_next = S_START;
            S_START: begin
                if (spi_busy_i)      w_next = S_XFER;
                else if (w_start_to) w_next = S_DONE;
            end
            S_XFER:  if (w_capture || w_xfer_to) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge GCLK) begin
        if (RST) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_ready0 <= 1'b0;
            r_ready1 <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_start  <= 1'b0;
            r_mode   <= '0;
            r_speed  <= '0;
            r_len    <= '0;
            r_mosi   <= '0;
            r_miso0  <= '0;
            r_miso1  <= '0;
        end else begin
            r_ready0 <= w_grant && !w_grant_id;
            r_ready1 <= w_grant &&  w_grant_id;
            r_done0  <= w_finish && !r_owner;
            r_done1  <= w_finish &&  r_owner;
            if (w_grant) begin
                r_owner <= w_grant_id;
                r_last  <= w_grant_id;
                r_mode  <= w_grant_id ? req1_mode_i  : req0_mode_i;
                r_speed <= w_grant_id ? req1_speed_i : req0_speed_i;
                r_len   <= w_grant_id ? req1_len_i   : req0_len_i;
                r_mosi  <= w_grant_id ? req1_mosi_i  : req0_mosi_i;
            end
            if (r_state == S_LOAD)
                r_start <= 1'b1;
            else if (r_state == S_START && (spi_busy_i || w_start_to))
                r_start <= 1'b0;
            if (w_capture) begin
                if (r_owner) r_miso1 <= spi_miso_i;
                else         r_miso0 <= spi_miso_i;
            end
        end
    end

    assign req0_ready_o = r_ready0;
    assign req1_ready_o = r_ready1;
    assign req0_done_o  = r_done0;
    assign req1_done_o  = r_done1;
    assign req0_miso_o  = r_miso0;
    assign req1_miso_o  = r_miso1;
    assign spi_start_o  = r_start;
    assign spi_mode_o   = r_mode;
    assign spi_speed_o  = r_speed;
    assign spi_len_o    = r_len;
    assign spi_mosi_o   = r_mosi;
    assign ifg_o        = ifg_i;
    assign cs_sck_o     = cs_sck_i;
    assign sck_cs_o     = sck_cs_i;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter; the watchdog scenario adapts to SPI_ARB_WDOG_EN.
module tb_spi_arbiter;

    logic        GCLK = 1'b0;
    logic        RST;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o, req0_done_o, req1_done_o, req0_err_o, req1_err_o;
    logic [1:0]  req0_mode_i, req0_speed_i, req0_len_i, req1_mode_i, req1_speed_i, req1_len_i;
    logic [31:0] req0_mosi_i, req1_mosi_i, req0_miso_o, req1_miso_o;
    logic [7:0]  ifg_i, cs_sck_i, sck_cs_i, ifg_o, cs_sck_o, sck_cs_o;
    logic        spi_start_o, spi_busy_i;
    logic [1:0]  spi_mode_o, spi_speed_o, spi_len_o;
    logic [31:0] spi_mosi_o, spi_miso_i;

    int n_vec = 0;
    int n_err = 0;
    int n_rdy0 = 0, n_rdy1 = 0, n_done0 = 0, n_done1 = 0;
    int s_rdy0, s_rdy1, s_done0, s_done1;

    spi_arbiter #(.START_TO(16), .XFER_TO(4096)) dut (
        .GCLK(GCLK), .RST(RST),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_mode_i(req0_mode_i), .req0_speed_i(req0_speed_i), .req0_len_i(req0_len_i),
        .req0_mosi_i(req0_mosi_i), .req0_done_o(req0_done_o), .req0_miso_o(req0_miso_o),
        .req0_err_o(req0_err_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_mode_i(req1_mode_i), .req1_speed_i(req1_speed_i), .req1_len_i(req1_len_i),
        .req1_mosi_i(req1_mosi_i), .req1_done_o(req1_done_o), .req1_miso_o(req1_miso_o),
        .req1_err_o(req1_err_o),
        .ifg_i(ifg_i), .cs_sck_i(cs_sck_i), .sck_cs_i(sck_cs_i),
        .ifg_o(ifg_o), .cs_sck_o(cs_sck_o), .sck_cs_o(sck_cs_o),
        .spi_start_o(spi_start_o), .spi_busy_i(spi_busy_i),
        .spi_mode_o(spi_mode_o), .spi_speed_o(spi_speed_o), .spi_len_o(spi_len_o),
        .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i)
    );

    always #5 GCLK = ~GCLK;

    // Pulse counters sample pre-edge values at each rising edge.
    always @(posedge GCLK) begin
        n_rdy0  <= n_rdy0  + int'(req0_ready_o);
        n_rdy1  <= n_rdy1  + int'(req1_ready_o);
        n_done0 <= n_done0 + int'(req0_done_o);
        n_done1 <= n_done1 + int'(req1_done_o);
    end

    task automatic tick;
        @(negedge GCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge in IDLE with the owner's request already valid;
    // ends at a falling edge back in IDLE.
    task automatic run_txn(input logic own, input logic [31:0] exp_mosi, input logic [5:0] exp_cfg,
                           input int start_wait, input int busy_cyc, input logic [31:0] miso_val,
                           input logic release_req, input int poke_at);
        tick;
        chk("ready_own",   own ? 32'(req1_ready_o) : 32'(req0_ready_o), 32'd1);
        chk("ready_other", own ? 32'(req0_ready_o) : 32'(req1_ready_o), 32'd0);
        chk("load_mosi",   spi_mosi_o, exp_mosi);
        chk("load_cfg",    32'({spi_mode_o, spi_speed_o, spi_len_o}), 32'(exp_cfg));
        if (release_req) begin
            if (own) begin
                req1_valid_i = 1'b0;
                req1_mosi_i  = ~exp_mosi;
                {req1_mode_i, req1_speed_i, req1_len_i} = ~exp_cfg;
            end else begin
                req0_valid_i = 1'b0;
                req0_mosi_i  = ~exp_mosi;
                {req0_mode_i, req0_speed_i, req0_len_i} = ~exp_cfg;
            end
        end
        tick;
        chk("start_high", 32'(spi_start_o), 32'd1);
        for (int i = 0; i < start_wait; i++) begin
            tick;
            chk("start_held", 32'(spi_start_o), 32'd1);
        end
        spi_busy_i = 1'b1;
        tick;
        chk("start_drop", 32'(spi_start_o), 32'd0);
        for (int i = 0; i < busy_cyc - 1; i++) begin
            tick;
            chk("xfer_mosi_stable", spi_mosi_o, exp_mosi);
            if (i == poke_at)     req1_valid_i = 1'b1;
            if (i == poke_at + 1) req1_valid_i = 1'b0;
        end
        spi_busy_i = 1'b0;
        spi_miso_i = miso_val;
        tick;
        chk("done_own",   own ? 32'(req1_done_o) : 32'(req0_done_o), 32'd1);
        chk("done_other", own ? 32'(req0_done_o) : 32'(req1_done_o), 32'd0);
        chk("err_own",    own ? 32'(req1_err_o)  : 32'(req0_err_o),  32'd0);
        chk("miso_own",   own ? req1_miso_o : req0_miso_o, miso_val);
        chk("done_cfg",   32'({spi_mode_o, spi_speed_o, spi_len_o}), 32'(exp_cfg));
        chk("done_mosi",  spi_mosi_o, exp_mosi);
        tick;
        chk("done_single", own ? 32'(req1_done_o) : 32'(req0_done_o), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        {req0_mode_i, req0_speed_i, req0_len_i} = '0;
        {req1_mode_i, req1_speed_i, req1_len_i} = '0;
        req0_mosi_i = '0; req1_mosi_i = '0;
        spi_busy_i = 1'b0; spi_miso_i = '0;
        ifg_i = 8'h11; cs_sck_i = 8'h22; sck_cs_i = 8'h33;
        tick; tick;

        // reset state and pass-through
        chk("rst_start",  32'(spi_start_o), 32'd0);
        chk("rst_ready",  32'({req0_ready_o, req1_ready_o}), 32'd0);
        chk("rst_done",   32'({req0_done_o, req1_done_o}), 32'd0);
        chk("rst_err",    32'({req0_err_o, req1_err_o}), 32'd0);
        chk("rst_mosi",   spi_mosi_o, 32'd0);
        chk("rst_cfg",    32'({spi_mode_o, spi_speed_o, spi_len_o}), 32'd0);
        chk("rst_miso0",  req0_miso_o, 32'd0);
        chk("rst_miso1",  req1_miso_o, 32'd0);
        chk("passthru",   {8'h0, ifg_o, cs_sck_o, sck_cs_o}, 32'h0011_2233);
        RST = 1'b0;
        tick;

        // round robin with both requests held: grants 0,1,0,1
        req0_mode_i = 2'd1; req0_speed_i = 2'd2; req0_len_i = 2'd3; req0_mosi_i = 32'h0000_00A0;
        req1_mode_i = 2'd3; req1_speed_i = 2'd0; req1_len_i = 2'd1; req1_mosi_i = 32'h0000_00B1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        run_txn(1'b0, 32'h0000_00A0, 6'b01_10_11, 0, 1, 32'h0000_00C0, 1'b0, -1);
        run_txn(1'b1, 32'h0000_00B1, 6'b11_00_01, 0, 1, 32'h0000_00C1, 1'b0, -1);
        run_txn(1'b0, 32'h0000_00A0, 6'b01_10_11, 0, 1, 32'h0000_00C2, 1'b0, -1);
        run_txn(1'b1, 32'h0000_00B1, 6'b11_00_01, 0, 1, 32'h0000_00C3, 1'b0, -1);
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tick;
        chk("rr_no_extra_grant", 32'({req0_ready_o, req1_ready_o}), 32'd0);
        chk("rr_ready_counts", 32'({n_rdy0[7:0], n_rdy1[7:0]}), 32'h0202);
        chk("rr_done_counts",  32'({n_done0[7:0], n_done1[7:0]}), 32'h0202);

        // single req0, long start wait and 40-cycle busy, requester changes fields after ready
        s_rdy0 = n_rdy0; s_rdy1 = n_rdy1; s_done0 = n_done0; s_done1 = n_done1;
        req0_mode_i = 2'd2; req0_speed_i = 2'd1; req0_len_i = 2'd2; req0_mosi_i = 32'hA5A5_0001;
        req0_valid_i = 1'b1;
        run_txn(1'b0, 32'hA5A5_0001, 6'b10_01_10, 2, 40, 32'h1234_5678, 1'b1, -1);
        tick; tick;
        chk("single_idle_start", 32'(spi_start_o), 32'd0);
        chk("single_rdy0_once",  32'(n_rdy0 - s_rdy0), 32'd1);
        chk("single_done0_once", 32'(n_done0 - s_done0), 32'd1);
        chk("single_req1_quiet", 32'((n_rdy1 - s_rdy1) + (n_done1 - s_done1)), 32'd0);
        chk("single_miso1_kept", req1_miso_o, 32'h0000_00C3);

        // req1 pulses valid for one cycle while req0 is transferring
        s_rdy1 = n_rdy1; s_done1 = n_done1;
        req0_mode_i = 2'd0; req0_speed_i = 2'd3; req0_len_i = 2'd1; req0_mosi_i = 32'h0000_0033;
        req1_mosi_i = 32'h0BAD_0BAD;
        req0_valid_i = 1'b1;
        run_txn(1'b0, 32'h0000_0033, 6'b00_11_01, 0, 5, 32'h0000_3333, 1'b1, 1);
        tick; tick; tick;
        chk("withdraw_no_start", 32'(spi_start_o), 32'd0);
        chk("withdraw_no_ready1", 32'(n_rdy1 - s_rdy1), 32'd0);
        chk("withdraw_no_done1",  32'(n_done1 - s_done1), 32'd0);

        // reset in the middle of XFER
        s_done0 = n_done0;
        req0_mosi_i = 32'h0000_0032; req0_valid_i = 1'b1;
        tick;
        chk("rx_ready0", 32'(req0_ready_o), 32'd1);
        req0_valid_i = 1'b0;
        tick;
        spi_busy_i = 1'b1;
        tick;
        chk("rx_in_xfer", 32'(spi_start_o), 32'd0);
        RST = 1'b1;
        tick;
        chk("rx_start0", 32'(spi_start_o), 32'd0);
        chk("rx_done0",  32'(req0_done_o), 32'd0);
        chk("rx_mosi0",  spi_mosi_o, 32'd0);
        chk("rx_miso0",  req0_miso_o, 32'd0);
        RST = 1'b0; spi_busy_i = 1'b0; spi_miso_i = 32'h5555_AAAA;
        tick; tick;
        chk("rx_no_late_done", 32'({req0_done_o, req0_err_o}), 32'd0);
        chk("rx_done_count",   32'(n_done0 - s_done0), 32'd0);
        req1_mode_i = 2'd2; req1_speed_i = 2'd2; req1_len_i = 2'd0; req1_mosi_i = 32'h1111_0032;
        req1_valid_i = 1'b1;
        run_txn(1'b1, 32'h1111_0032, 6'b10_10_00, 0, 3, 32'h2222_0032, 1'b1, -1);

        // master never raises busy
        spi_miso_i = 32'hDEAD_BEEF;
        req0_mosi_i = 32'h0000_0034; req0_valid_i = 1'b1;
        tick;
        chk("wd_ready0", 32'(req0_ready_o), 32'd1);
        req0_valid_i = 1'b0;
        tick;
        chk("wd_start", 32'(spi_start_o), 32'd1);
`ifdef SPI_ARB_WDOG_EN
        repeat (15) tick;
        chk("wd_start_16th", 32'(spi_start_o), 32'd1);
        chk("wd_no_early_done", 32'(req0_done_o), 32'd0);
        tick;
        chk("wd_done_err", 32'({req0_done_o, req0_err_o}), 32'h3);
        chk("wd_start_drop", 32'(spi_start_o), 32'd0);
        chk("wd_miso_kept", req0_miso_o, 32'd0);
        chk("wd_req1_quiet", 32'({req1_done_o, req1_err_o}), 32'd0);
        tick;
        chk("wd_pulse_end", 32'({req0_done_o, req0_err_o}), 32'd0);
`else
        repeat (20) tick;
        chk("nowd_still_start", 32'(spi_start_o), 32'd1);
        chk("nowd_no_done", 32'({req0_done_o, req0_err_o}), 32'd0);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("nowd_reset_start", 32'(spi_start_o), 32'd0);
`endif
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter START_TO, default 16: cycles allowed from spi_start_o assertion to spi_busy_i high (used only with SPI_ARB_WDOG_EN).
REQ-002 Parameter XFER_TO, default 4096: cycles allowed with spi_busy_i high before abort (used only with SPI_ARB_WDOG_EN).
REQ-003 GCLK  in  1  sole clock; all logic on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 reqN_valid_i  in  1  (N=0,1) transaction request, level, held until reqN_ready_o.
REQ-006 reqN_ready_o  out  1  one-cycle acceptance pulse; request fields sampled this cycle.
REQ-007 reqN_mode_i / reqN_speed_i / reqN_len_i  in  2 each  SPI mode, SCK speed, word length of request.
REQ-008 reqN_mosi_i  in  32  transmit word.
REQ-009 reqN_done_o  out  1  one-cycle completion pulse to the owning requester.
REQ-010 reqN_miso_o  out  32  received word, valid from reqN_done_o, held until next completion for N.
REQ-011 reqN_err_o  out  1  qualifies reqN_done_o: 1 = aborted by watchdog (constant 0 without SPI_ARB_WDOG_EN).
REQ-012 ifg_i / cs_sck_i / sck_cs_i  in  8 each  shared timing; forwarded unchanged to ifg_o / cs_sck_o / sck_cs_o (out, 8 each).
REQ-013 spi_start_o  out  1; spi_busy_i  in  1; spi_mode_o / spi_speed_o / spi_len_o  out  2 each; spi_mosi_o  out  32; spi_miso_i  in  32 -- SPI master side.

Function
REQ-014 FSM states IDLE, LOAD, START, XFER, DONE; all outputs registered except the timing pass-through.
REQ-015 IDLE: if any reqN_valid_i high, grant one, pulse its reqN_ready_o, latch its mode/speed/len/mosi and owner id, go LOAD; else stay.
REQ-016 Arbitration round-robin: both valid -> grant the requester not granted last; last-grant pointer resets to 1 (req0 wins first tie).
REQ-017 LOAD: drive latched fields on spi_mode_o/spi_speed_o/spi_len_o/spi_mosi_o; one cycle; go START.
REQ-018 spi_* config outputs SHALL stay constant from LOAD through DONE.
REQ-019 START: spi_start_o = 1; on first cycle spi_busy_i = 1, deassert spi_start_o next cycle and go XFER.
REQ-020 XFER: on first cycle spi_busy_i = 0, capture spi_miso_i into owner's reqN_miso_o, go DONE.
REQ-021 DONE: pulse owner's reqN_done_o for exactly one cycle; return IDLE; new grant earliest next cycle.
REQ-022 Minimum IDLE->IDLE turnaround with busy low 1 cycle after start high: 5 cycles + busy-high duration.
REQ-023 reqN_valid_i dropped before its ready pulse: request withdrawn, no transaction, no done.
REQ-024 reqN_valid_i of the owner ignored while not IDLE; new request accepted only after its DONE.
REQ-025 spi_busy_i high while in IDLE/LOAD ignored; START waits for busy rising behaviour as per REQ-019 only.

Reset
REQ-026 RST high at any edge: next state IDLE, spi_start_o 0, all ready/done/err 0, spi_* config and mosi 0, reqN_miso_o 0, last-grant 1, watchdog counter 0.
REQ-027 Reset mid-transaction SHALL NOT produce done or err pulse; owner must re-request.

Configuration
REQ-028 Macro SPI_ARB_WDOG_EN defined: 16-bit counter clears on entering START and XFER; START exceeding START_TO cycles or XFER exceeding XFER_TO cycles -> drop spi_start_o, go DONE with reqN_err_o = 1 alongside done, reqN_miso_o unchanged.
REQ-029 SPI_ARB_WDOG_EN undefined: no counter logic, START/XFER wait indefinitely, reqN_err_o tied 0.

Verification
REQ-030 Single req0, mosi 0xA5A5_0001, mode 2, busy high 2 cycles after start for 40 cycles, miso 0x1234_5678 -> one ready0, start held until busy, done0 once, req0_miso_o = 0x1234_5678, req1 outputs idle.
REQ-031 req0 and req1 valid same cycle after reset, held continuously -> grants 0,1,0,1 in order; each done to correct owner; spi_mosi_o matches owner's data per transaction.
REQ-032 RST pulsed during XFER -> spi_start_o 0 next cycle, no done, next request served normally from IDLE.
REQ-033 req1 valid for 1 cycle while req0 in XFER, then dropped -> req1 never granted, no req1 ready/done.
REQ-034 With SPI_ARB_WDOG_EN, START_TO 16, spi_busy_i never rises -> after 16 START cycles done0 with err0 = 1, spi_start_o 0; without macro, FSM remains in START.
REQ-035 Config outputs monitored LOAD..DONE while requester changes its inputs after ready -> spi_mode_o/spi_speed_o/spi_len_o/spi_mosi_o unchanged.
